// File: rtl/bus_decoder_reg_if.sv
// ============================================================
// bus_decoder_reg_if : master-side and slave-array bus bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface bus_decoder_reg_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3
);
  logic                                  valid_i;
  logic [ADDR_WIDTH-1:0]                 addr_i;
  logic [DATA_WIDTH-1:0]                 wdata_i;
  logic                                  we_i;
  logic                                  ready_o;
  logic [DATA_WIDTH-1:0]                 rdata_o;
  logic                                  err_o;
  logic                                  busy_o;
  logic                                  timeout_o;
  logic [NUM_SLAVES-1:0]                 slave_sel_o;
  logic [NUM_SLAVES-1:0]                 slave_valid_o;
  logic [ADDR_WIDTH-1:0]                 slave_addr_o;
  logic [DATA_WIDTH-1:0]                 slave_wdata_o;
  logic                                  slave_we_o;
  logic [NUM_SLAVES-1:0]                 slave_ready_i;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] slave_rdata_i;
  logic [NUM_SLAVES-1:0]                 slave_err_i;

  // Decoder side
  modport slave (
    input  valid_i, addr_i, wdata_i, we_i,
    input  slave_ready_i, slave_rdata_i, slave_err_i,
    output ready_o, rdata_o, err_o, busy_o, timeout_o,
    output slave_sel_o, slave_valid_o, slave_addr_o, slave_wdata_o, slave_we_o
  );

  // Environment side: bus master plus slave array
  modport master (
    output valid_i, addr_i, wdata_i, we_i,
    output slave_ready_i, slave_rdata_i, slave_err_i,
    input  ready_o, rdata_o, err_o, busy_o, timeout_o,
    input  slave_sel_o, slave_valid_o, slave_addr_o, slave_wdata_o, slave_we_o
  );
endinterface

`default_nettype wire

// File: rtl/bus_decoder_reg.sv
// ============================================================
// bus_decoder_reg : registered address decoder with slave timeout
// Rev 1.0
// ============================================================
`default_nettype none

module bus_decoder_reg #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SLAVES     = 3,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE =
    {14'h2000, 14'h1000, 14'h0000},
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH:0]   SLAVE_SIZE =
    {15'h0800, 15'h1000, 15'h1000},
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bus_decoder_reg_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, ACCESS, DECERR, RESP} state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;

  logic [NUM_SLAVES-1:0]                 hit;
  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] local_addr;
  logic [NUM_SLAVES-1:0]                 dec_sel;
  logic [ADDR_WIDTH-1:0]                 dec_addr;
  logic                                  sel_ready;
  logic                                  sel_err;
  logic [DATA_WIDTH-1:0]                 sel_rdata;
  logic                                  timeout_hit;

  // Region compare widened by one bit so base+size cannot wrap
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      logic [ADDR_WIDTH:0] lo;
      logic [ADDR_WIDTH:0] hi;
      assign lo             = {1'b0, SLAVE_BASE[gi]};
      assign hi             = lo + SLAVE_SIZE[gi];
      assign hit[gi]        = ({1'b0, bus.addr_i} >= lo) && ({1'b0, bus.addr_i} < hi);
      assign local_addr[gi] = bus.addr_i - SLAVE_BASE[gi];
    end
  endgenerate

  always_comb begin
    dec_sel  = '0;
    dec_addr = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
        dec_addr   = local_addr[i];
      end
    end
  end

  always_comb begin
    sel_ready = |(bus.slave_ready_i & sel_q);
    sel_err   = |(bus.slave_err_i & sel_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_rdata = bus.slave_rdata_i[i];
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          sel_d   = dec_sel;
          addr_d  = dec_addr;
          wdata_d = bus.wdata_i;
          we_d    = bus.we_i;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = (|dec_sel) ? ACCESS : DECERR;
        end
      end
      ACCESS: begin
        // A ready arriving on the timeout cycle still wins
        if (sel_ready) begin
          rdata_d = sel_rdata;
          err_d   = sel_err;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DECERR: begin
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.ready_o       = (state_q == RESP);
  assign bus.rdata_o       = (state_q == RESP) ? rdata_q : '0;
  assign bus.err_o         = (state_q == RESP) ? err_q : 1'b0;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.timeout_o     = timeout_q;
  assign bus.slave_sel_o   = (state_q == ACCESS) ? sel_q : '0;
  assign bus.slave_valid_o = (state_q == ACCESS) ? sel_q : '0;
  assign bus.slave_addr_o  = (state_q == ACCESS) ? addr_q : '0;
  assign bus.slave_wdata_o = (state_q == ACCESS) ? wdata_q : '0;
  assign bus.slave_we_o    = (state_q == ACCESS) ? we_q : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_bus_decoder_reg.sv
// ============================================================
// tb_bus_decoder_reg : directed self-checking bench for bus_decoder_reg
// Rev 1.0
// ============================================================
`default_nettype none

module tb_bus_decoder_reg;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bus_decoder_reg_if #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .NUM_SLAVES(3)) bus ();

  bus_decoder_reg dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.valid_i       = 1'b0;
    bus.addr_i        = '0;
    bus.wdata_i       = '0;
    bus.we_i          = 1'b0;
    bus.slave_ready_i = '0;
    bus.slave_rdata_i = '0;
    bus.slave_err_i   = '0;
  endtask

  task automatic test_reset();
    logic [42:0] outs;
    rst = 1'b1;
    bus_idle();
    #1;
    outs = {bus.ready_o, bus.err_o, bus.rdata_o, bus.busy_o, bus.timeout_o,
            bus.slave_sel_o, bus.slave_valid_o, bus.slave_addr_o,
            bus.slave_wdata_o, bus.slave_we_o};
    checks++;
    if (outs !== 43'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o);
    end
  endtask

  task automatic test_decode_hits();
    logic [13:0] addrs [3] = '{14'h0FFF, 14'h1000, 14'h27FF};
    logic [13:0] laddr [3] = '{14'h0FFF, 14'h0000, 14'h07FF};
    logic [2:0]  sels  [3] = '{3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 3; k++) begin
      bus.valid_i = 1'b1; bus.addr_i = addrs[k]; bus.we_i = 1'b1; bus.wdata_i = 8'h42;
      @(negedge clk);
      checks++;
      if ({bus.slave_sel_o, bus.slave_valid_o, bus.slave_addr_o, bus.slave_wdata_o, bus.slave_we_o}
          !== {sels[k], sels[k], laddr[k], 8'h42, 1'b1}) begin
        failures++;
        $display("FAIL hit_access[%0d] got sel=%b valid=%b addr=%h wdata=%h we=%b exp sel=%b addr=%h wdata=42 we=1",
                 k, bus.slave_sel_o, bus.slave_valid_o, bus.slave_addr_o, bus.slave_wdata_o,
                 bus.slave_we_o, sels[k], laddr[k]);
      end
      bus.slave_ready_i = sels[k];
      @(negedge clk);
      checks++;
      if ({bus.ready_o, bus.err_o, bus.rdata_o, bus.slave_valid_o} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
        failures++;
        $display("FAIL hit_resp[%0d] got ready=%b err=%b rdata=%h valid=%b exp ready=1 err=0 rdata=00 valid=000",
                 k, bus.ready_o, bus.err_o, bus.rdata_o, bus.slave_valid_o);
      end
      bus_idle();
      @(negedge clk);
    end
  endtask

  task automatic test_unmapped();
    logic [13:0] addrs [2] = '{14'h2800, 14'h3FFF};
    for (int k = 0; k < 2; k++) begin
      bus.valid_i = 1'b1; bus.addr_i = addrs[k]; bus.we_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.slave_valid_o, bus.busy_o, bus.ready_o} !== {3'b000, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL unmapped_decerr[%0d] got valid=%b busy=%b ready=%b exp valid=000 busy=1 ready=0",
                 k, bus.slave_valid_o, bus.busy_o, bus.ready_o);
      end
      @(negedge clk);
      checks++;
      if ({bus.ready_o, bus.err_o, bus.rdata_o, bus.slave_valid_o} !== {1'b1, 1'b1, 8'h00, 3'b000}) begin
        failures++;
        $display("FAIL unmapped_resp[%0d] got ready=%b err=%b rdata=%h exp ready=1 err=1 rdata=00",
                 k, bus.ready_o, bus.err_o, bus.rdata_o);
      end
      bus_idle();
      @(negedge clk);
    end
  endtask

  task automatic test_read_wait();
    logic early;
    bus.valid_i = 1'b1; bus.addr_i = 14'h1800; bus.we_i = 1'b0;
    bus.slave_rdata_i[0] = 8'h11;
    @(negedge clk);
    checks++;
    if ({bus.slave_valid_o, bus.slave_addr_o, bus.slave_we_o} !== {3'b010, 14'h0800, 1'b0}) begin
      failures++;
      $display("FAIL read_access got valid=%b addr=%h we=%b exp valid=010 addr=0800 we=0",
               bus.slave_valid_o, bus.slave_addr_o, bus.slave_we_o);
    end
    early = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0 || bus.slave_valid_o !== 3'b010) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++; $display("FAIL read_wait got early_response=%b exp 0", early);
    end
    bus.slave_ready_i = 3'b010;
    bus.slave_rdata_i[1] = 8'hCD;
    @(negedge clk);
    checks++;
    if ({bus.ready_o, bus.rdata_o, bus.err_o} !== {1'b1, 8'hCD, 1'b0}) begin
      failures++;
      $display("FAIL read_resp got ready=%b rdata=%h err=%b exp ready=1 rdata=cd err=0",
               bus.ready_o, bus.rdata_o, bus.err_o);
    end
    bus_idle();
    @(negedge clk);
    checks++;
    if ({bus.ready_o, bus.rdata_o, bus.busy_o} !== {1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL read_one_cycle got ready=%b rdata=%h busy=%b exp ready=0 rdata=00 busy=0",
               bus.ready_o, bus.rdata_o, bus.busy_o);
    end
  endtask

  task automatic test_timeout();
    logic early;
    bus.valid_i = 1'b1; bus.addr_i = 14'h2100; bus.we_i = 1'b0;
    bus.slave_rdata_i[2] = 8'h77;
    bus.slave_rdata_i[0] = 8'h55;
    @(negedge clk);
    checks++;
    if ({bus.slave_valid_o, bus.slave_addr_o} !== {3'b100, 14'h0100}) begin
      failures++;
      $display("FAIL timeout_access got valid=%b addr=%h exp valid=100 addr=0100",
               bus.slave_valid_o, bus.slave_addr_o);
    end
    early = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      bus.slave_ready_i = (c == 3) ? 3'b001 : 3'b000;
      bus.slave_err_i   = (c == 3) ? 3'b001 : 3'b000;
      @(negedge clk);
      if (bus.ready_o !== 1'b0 || bus.timeout_o !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++; $display("FAIL timeout_early got early_response=%b exp 0", early);
    end
    bus.slave_ready_i = '0;
    bus.slave_err_i   = '0;
    @(negedge clk);
    checks++;
    if ({bus.ready_o, bus.timeout_o, bus.err_o, bus.rdata_o} !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL timeout_resp got ready=%b timeout=%b err=%b rdata=%h exp ready=1 timeout=1 err=1 rdata=00",
               bus.ready_o, bus.timeout_o, bus.err_o, bus.rdata_o);
    end
    bus_idle();
    @(negedge clk);
    checks++;
    if ({bus.timeout_o, bus.ready_o} !== 2'b00) begin
      failures++;
      $display("FAIL timeout_pulse got timeout=%b ready=%b exp 0 0", bus.timeout_o, bus.ready_o);
    end
  endtask

  task automatic test_back_to_back();
    bus.valid_i = 1'b1; bus.addr_i = 14'h0100; bus.we_i = 1'b1; bus.wdata_i = 8'h5A;
    @(negedge clk);
    checks++;
    if ({bus.slave_valid_o, bus.slave_addr_o, bus.slave_wdata_o} !== {3'b001, 14'h0100, 8'h5A}) begin
      failures++;
      $display("FAIL b2b_first_access got valid=%b addr=%h wdata=%h exp valid=001 addr=0100 wdata=5a",
               bus.slave_valid_o, bus.slave_addr_o, bus.slave_wdata_o);
    end
    bus.slave_ready_i = 3'b001; bus.slave_err_i = 3'b001;
    @(negedge clk);
    checks++;
    if ({bus.ready_o, bus.err_o} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_first_resp got ready=%b err=%b exp ready=1 err=1", bus.ready_o, bus.err_o);
    end
    bus.slave_ready_i = '0; bus.slave_err_i = '0;
    bus.addr_i = 14'h1100; bus.wdata_i = 8'hA5;
    @(negedge clk);
    checks++;
    if ({bus.busy_o, bus.slave_valid_o, bus.ready_o} !== {1'b0, 3'b000, 1'b0}) begin
      failures++;
      $display("FAIL b2b_idle_gap got busy=%b valid=%b ready=%b exp busy=0 valid=000 ready=0",
               bus.busy_o, bus.slave_valid_o, bus.ready_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.slave_valid_o, bus.slave_addr_o, bus.slave_wdata_o} !== {3'b010, 14'h0100, 8'hA5}) begin
      failures++;
      $display("FAIL b2b_second_access got valid=%b addr=%h wdata=%h exp valid=010 addr=0100 wdata=a5",
               bus.slave_valid_o, bus.slave_addr_o, bus.slave_wdata_o);
    end
    bus.slave_ready_i = 3'b010;
    @(negedge clk);
    checks++;
    if ({bus.ready_o, bus.err_o} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_second_resp got ready=%b err=%b exp ready=1 err=0", bus.ready_o, bus.err_o);
    end
    bus_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [42:0] outs;
    bus.valid_i = 1'b1; bus.addr_i = 14'h1234; bus.we_i = 1'b1; bus.wdata_i = 8'h99;
    @(negedge clk);
    checks++;
    if ({bus.slave_valid_o, bus.slave_addr_o} !== {3'b010, 14'h0234}) begin
      failures++;
      $display("FAIL rstmid_access got valid=%b addr=%h exp valid=010 addr=0234",
               bus.slave_valid_o, bus.slave_addr_o);
    end
    #2 rst = 1'b1;
    #1;
    outs = {bus.ready_o, bus.err_o, bus.rdata_o, bus.busy_o, bus.timeout_o,
            bus.slave_sel_o, bus.slave_valid_o, bus.slave_addr_o,
            bus.slave_wdata_o, bus.slave_we_o};
    checks++;
    if (outs !== 43'd0) begin
      failures++; $display("FAIL rstmid_async got=%h exp=0", outs);
    end
    bus_idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy_o, bus.ready_o} !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_after got busy=%b ready=%b exp 0 0", bus.busy_o, bus.ready_o);
    end
    bus.valid_i = 1'b1; bus.addr_i = 14'h0000; bus.we_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.slave_valid_o, bus.slave_addr_o} !== {3'b001, 14'h0000}) begin
      failures++;
      $display("FAIL rstmid_fresh_access got valid=%b addr=%h exp valid=001 addr=0000",
               bus.slave_valid_o, bus.slave_addr_o);
    end
    bus.slave_ready_i = 3'b001; bus.slave_rdata_i[0] = 8'h3C;
    @(negedge clk);
    checks++;
    if ({bus.ready_o, bus.rdata_o, bus.err_o} !== {1'b1, 8'h3C, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_fresh_resp got ready=%b rdata=%h err=%b exp ready=1 rdata=3c err=0",
               bus.ready_o, bus.rdata_o, bus.err_o);
    end
    bus_idle();
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_decode_hits();
    test_unmapped();
    test_read_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
